// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Stats width is also used by the optional MEM_ARBITER_STATS_EN counters.
package mem_arbiter_pkg;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_idx_t;

    localparam int       STATS_W    = 16;
    localparam req_idx_t RESET_PRIO = REQ_0;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to i_prio.
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
(
    input  logic     i_req0,
    input  logic     i_req1,
    input  req_idx_t i_prio,
    output logic     o_grant0,
    output logic     o_grant1
);

    logic w_tie;

    assign w_tie    = i_req0 & i_req1;
    assign o_grant0 = i_req0 & (~w_tie | (i_prio == REQ_0));
    assign o_grant1 = i_req1 & (~w_tie | (i_prio == REQ_1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory shared by two requesters through a round-robin arbiter.
// Define MEM_ARBITER_STATS_EN to add saturating grant/conflict counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              req0,
    input  logic              req1,
    input  logic              writeEnable0,
    input  logic              writeEnable1,
    input  logic [DEPTH-1:0]  address0,
    input  logic [DEPTH-1:0]  address1,
    input  logic [WIDTH-1:0]  writeData0,
    input  logic [WIDTH-1:0]  writeData1,
    output logic              grant0,
    output logic              grant1,
    output logic              readValid0,
    output logic              readValid1,
    output logic [WIDTH-1:0]  readData
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [STATS_W-1:0] grantCount0,
    output logic [STATS_W-1:0] grantCount1,
    output logic [STATS_W-1:0] conflictCount
`endif
);

    logic             w_req0;
    logic             w_req1;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_access;
    logic             w_we;
    logic [DEPTH-1:0] w_addr;
    logic [WIDTH-1:0] w_wdata;

    req_idx_t         r_prio;
    logic             r_rvalid0;
    logic             r_rvalid1;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] r_mem [2**DEPTH];

    // Requests are masked while in reset so no grant can escape.
    assign w_req0 = req0 & resetN;
    assign w_req1 = req1 & resetN;

    mem_arbiter_rr u_rr (
        .i_req0   (w_req0),
        .i_req1   (w_req1),
        .i_prio   (r_prio),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    assign w_access = w_grant0 | w_grant1;
    assign w_we     = w_grant1 ? writeEnable1 : writeEnable0;
    assign w_addr   = w_grant1 ? address1     : address0;
    assign w_wdata  = w_grant1 ? writeData1   : writeData0;

    // Storage is deliberately not reset so contents survive a resetN pulse.
    always_ff @(posedge clock) begin
        if (w_access && w_we) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_prio    <= RESET_PRIO;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid0 <= w_grant0 & ~writeEnable0;
            r_rvalid1 <= w_grant1 & ~writeEnable1;
            if (w_access && !w_we) begin
                r_rdata <= r_mem[w_addr];
            end
            if (w_access) begin
                r_prio <= w_grant0 ? REQ_1 : REQ_0;
            end
        end
    end

    assign grant0     = w_grant0;
    assign grant1     = w_grant1;
    assign readValid0 = r_rvalid0;
    assign readValid1 = r_rvalid1;
    assign readData   = r_rdata;

`ifdef MEM_ARBITER_STATS_EN
    logic [STATS_W-1:0] r_gcnt0;
    logic [STATS_W-1:0] r_gcnt1;
    logic [STATS_W-1:0] r_ccnt;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_gcnt0 <= '0;
            r_gcnt1 <= '0;
            r_ccnt  <= '0;
        end else begin
            if (w_grant0 && (r_gcnt0 != '1)) r_gcnt0 <= r_gcnt0 + STATS_W'(1);
            if (w_grant1 && (r_gcnt1 != '1)) r_gcnt1 <= r_gcnt1 + STATS_W'(1);
            if (req0 && req1 && (r_ccnt != '1)) r_ccnt <= r_ccnt + STATS_W'(1);
        end
    end

    assign grantCount0   = r_gcnt0;
    assign grantCount1   = r_gcnt1;
    assign conflictCount = r_ccnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; stats checks are compiled in with MEM_ARBITER_STATS_EN.
module tb_mem_arbiter;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clock;
    logic             resetN;
    logic             req0, req1;
    logic             writeEnable0, writeEnable1;
    logic [DEPTH-1:0] address0, address1;
    logic [WIDTH-1:0] writeData0, writeData1;
    logic             grant0, grant1;
    logic             readValid0, readValid1;
    logic [WIDTH-1:0] readData;
`ifdef MEM_ARBITER_STATS_EN
    logic [15:0]      grantCount0, grantCount1, conflictCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock        (clock),
        .resetN       (resetN),
        .req0         (req0),
        .req1         (req1),
        .writeEnable0 (writeEnable0),
        .writeEnable1 (writeEnable1),
        .address0     (address0),
        .address1     (address1),
        .writeData0   (writeData0),
        .writeData1   (writeData1),
        .grant0       (grant0),
        .grant1       (grant1),
        .readValid0   (readValid0),
        .readValid1   (readValid1),
        .readData     (readData)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .grantCount0  (grantCount0),
        .grantCount1  (grantCount1),
        .conflictCount(conflictCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0;
        writeEnable0 = 1'b0; writeEnable1 = 1'b0;
        address0 = '0; address1 = '0;
        writeData0 = '0; writeData1 = '0;
    endtask

    task automatic drive0(input logic we, input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
        req0 = 1'b1; writeEnable0 = we; address0 = a; writeData0 = d;
    endtask

    task automatic drive1(input logic we, input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
        req1 = 1'b1; writeEnable1 = we; address1 = a; writeData1 = d;
    endtask

    initial begin
        idle();
        resetN = 1'b0;
        drive0(1'b0, 4'd3, 8'h00);
        #1;
        chk("rst_grant0", grant0, 1'b0);
        chk("rst_rvalid0", readValid0, 1'b0);
        chk("rst_rdata", readData, 8'h00);
        tick();
        tick();
        resetN = 1'b1;
        idle();

        // write then read back addr 3; requester 1 inputs toggle without req1
        drive0(1'b1, 4'd3, 8'hA5);
        drive1(1'b1, 4'd3, 8'hFF);
        req1 = 1'b0;
        #1;
        chk("wr_grant0", grant0, 1'b1);
        chk("wr_grant1", grant1, 1'b0);
        tick();
        chk("wr_rvalid0", readValid0, 1'b0);
        chk("wr_rdata_kept", readData, 8'h00);
        drive0(1'b0, 4'd3, 8'h00);
        #1;
        chk("rd_grant0", grant0, 1'b1);
        tick();
        chk("rd_rvalid0", readValid0, 1'b1);
        chk("rd_rvalid1", readValid1, 1'b0);
        chk("rd_rdata", readData, 8'hA5);
        idle();
        #1;
        chk("idle_grant0", grant0, 1'b0);
        tick();
        chk("idle_rvalid0", readValid0, 1'b0);
        chk("idle_rdata_hold", readData, 8'hA5);

        // req1 writes addr 7, req0 reads it on the very next edge
        drive1(1'b1, 4'd7, 8'h3C);
        #1;
        chk("w1_grant1", grant1, 1'b1);
        tick();
        idle();
        drive0(1'b0, 4'd7, 8'h00);
        #1;
        chk("r0_grant0", grant0, 1'b1);
        tick();
        chk("raw_rvalid0", readValid0, 1'b1);
        chk("raw_rvalid1", readValid1, 1'b0);
        chk("raw_rdata", readData, 8'h3C);
        idle();
        tick();

        // reset pulse right after a read grant; priority ends at 1 before this
        drive0(1'b0, 4'd3, 8'h00);
        tick();
        chk("prerst_rvalid0", readValid0, 1'b1);
        chk("prerst_rdata", readData, 8'hA5);
        resetN = 1'b0;
        #1;
        chk("async_rvalid0", readValid0, 1'b0);
        chk("async_rdata", readData, 8'h00);
        chk("async_grant0", grant0, 1'b0);
        tick();
        chk("inrst_rvalid0", readValid0, 1'b0);
        resetN = 1'b1;
        idle();
        tick();
        chk("postrst_rvalid0", readValid0, 1'b0);

        // simultaneous reads alternate starting with requester 0
        drive0(1'b0, 4'd3, 8'h00);
        drive1(1'b0, 4'd7, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("alt_grant0_%0d", i), grant0, (i % 2) == 0);
            chk($sformatf("alt_grant1_%0d", i), grant1, (i % 2) == 1);
            tick();
            chk($sformatf("alt_rvalid0_%0d", i), readValid0, (i % 2) == 0);
            chk($sformatf("alt_rvalid1_%0d", i), readValid1, (i % 2) == 1);
            chk($sformatf("alt_rdata_%0d", i), readData, ((i % 2) == 0) ? 8'hA5 : 8'h3C);
        end
        idle();
        tick();
        chk("alt_end_rvalid1", readValid1, 1'b0);
`ifdef MEM_ARBITER_STATS_EN
        chk("conflict_cnt", conflictCount, 16'd4);
        chk("gcnt0_after_alt", grantCount0, 16'd2);
        chk("gcnt1_after_alt", grantCount1, 16'd2);
`endif

        // storage survives reset
        drive0(1'b1, 4'd2, 8'h11);
        tick();
        idle();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        drive0(1'b0, 4'd2, 8'h00);
        tick();
        chk("keep_rvalid0", readValid0, 1'b1);
        chk("keep_rdata", readData, 8'h11);
        idle();
        tick();

`ifdef MEM_ARBITER_STATS_EN
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        #1;
        chk("stats_rst_gcnt0", grantCount0, 16'd0);
        drive0(1'b0, 4'd3, 8'h00);
        repeat (70000) @(posedge clock);
        #1;
        chk("sat_gcnt0", grantCount0, 16'hFFFF);
        chk("sat_gcnt1", grantCount1, 16'd0);
        idle();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
